// File: rtl/mips_fetch_if.sv
// ---------------------------------------------------------------------------
// mips_fetch_if
//   Bundles the fetch stage's decode-side and imem-side signals.
//   master : the fetch stage (drives imem_addr and the d_* outputs)
//   slave  : the surrounding pipeline / memory (drives enable, stall,
//            redirect and imem read data)
//   Signals:
//     en             global pipeline enable; 0 freezes the stage
//     stall          decode hazard stall; 1 = decode not accepting
//     redirect_valid decode resolved a taken branch/jump this cycle
//     redirect_pc    target byte address, bits [1:0] ignored
//     imem_addr      word address to instruction memory
//     imem_rdata     instruction memory data, valid the cycle after imem_addr
//     d_instr        instruction to decode, 0 when !d_valid
//     d_pc           byte address of d_instr
//     d_pc_plus4     d_pc + 4 (mod 2^32)
//     d_valid        d_instr is a real fetched instruction
// ---------------------------------------------------------------------------
interface mips_fetch_if #(
    parameter int unsigned IMEM_AW = 9
) ();
    logic               en;
    logic               stall;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic [31:0]        d_instr;
    logic [31:0]        d_pc;
    logic [31:0]        d_pc_plus4;
    logic               d_valid;

    modport master (
        input  en, stall, redirect_valid, redirect_pc, imem_rdata,
        output imem_addr, d_instr, d_pc, d_pc_plus4, d_valid
    );

    modport slave (
        output en, stall, redirect_valid, redirect_pc, imem_rdata,
        input  imem_addr, d_instr, d_pc, d_pc_plus4, d_valid
    );
endinterface

// File: rtl/mips_fetch_stage.sv
// ---------------------------------------------------------------------------
// mips_fetch_stage
//   Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, drives
//   a synchronous (1-cycle latency) instruction memory and presents
//   {instr, pc, pc+4, valid} to decode. Stalls and enable drops are absorbed
//   by a hold register; redirects from decode keep the branch delay slot.
//   Ports:
//     clk      pipeline clock, rising edge
//     rst_n    asynchronous active-low reset
//     io_fetch mips_fetch_if.master (enable/stall/redirect in, imem bus,
//              decode outputs)
// ---------------------------------------------------------------------------
module mips_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IMEM_AW  = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    mips_fetch_if.master  io_fetch
);

    logic [31:0] r_fetch_pc;
    logic [31:0] r_inflight_pc;
    logic        r_inflight_valid;
    logic [31:0] r_hold_instr;
    logic        r_hold_valid;

    logic        w_freeze;

    assign w_freeze = ~io_fetch.en | io_fetch.stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc       <= RESET_PC;
            r_inflight_pc    <= RESET_PC;
            r_inflight_valid <= 1'b0;
            r_hold_instr     <= '0;
            r_hold_valid     <= 1'b0;
        end else if (!w_freeze) begin
            r_inflight_pc    <= r_fetch_pc;
            r_inflight_valid <= 1'b1;
            r_hold_valid     <= 1'b0;
            // The instruction after the branch (already addressed) becomes
            // the delay slot; the target is fetched on this edge's successor.
            r_fetch_pc       <= io_fetch.redirect_valid
                              ? (io_fetch.redirect_pc & 32'hFFFF_FFFC)
                              : r_fetch_pc + 32'd4;
        end else if (!r_hold_valid) begin
            // First frozen edge: imem_rdata still belongs to inflight_pc, but
            // the memory re-reads fetch_pc on this edge, so capture it now.
            r_hold_instr     <= io_fetch.imem_rdata;
            r_hold_valid     <= r_inflight_valid;
        end
    end

    assign io_fetch.imem_addr  = r_fetch_pc[IMEM_AW+1:2];
    assign io_fetch.d_valid    = r_hold_valid | r_inflight_valid;
    assign io_fetch.d_instr    = r_hold_valid     ? r_hold_instr :
                                 r_inflight_valid ? io_fetch.imem_rdata : '0;
    assign io_fetch.d_pc       = r_inflight_pc;
    assign io_fetch.d_pc_plus4 = r_inflight_pc + 32'd4;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_mips_fetch_stage
//   Directed testbench for mips_fetch_stage. imem[i] = 32'h2008_0000 + i.
// ---------------------------------------------------------------------------
module tb_mips_fetch_stage;

    localparam int unsigned AW = 9;
    localparam logic [31:0] BASE = 32'h2008_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic [31:0] mem [512];

    mips_fetch_if #(.IMEM_AW(AW)) bus ();

    mips_fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .io_fetch (bus)
    );

    always #5 clk = ~clk;

    // synchronous instruction memory, one cycle read latency
    always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n              = 1'b0;
        bus.en             = 1'b0;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        repeat (2) @(posedge clk);
        #3;
        rst_n  = 1'b1;
        bus.en = 1'b1;
    endtask

    // check d_valid=1, d_pc, d_pc_plus4 and d_instr against the given values
    task automatic expect_out(input string name, input logic [31:0] pc,
                              input logic [31:0] instr);
        total++;
        if (bus.d_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s d_valid got=%b exp=1", name, bus.d_valid);
        end
        total++;
        if (bus.d_pc !== pc) begin
            bad++;
            $display("FAIL %s d_pc got=%h exp=%h", name, bus.d_pc, pc);
        end
        total++;
        if (bus.d_pc_plus4 !== pc + 32'd4) begin
            bad++;
            $display("FAIL %s d_pc_plus4 got=%h exp=%h", name, bus.d_pc_plus4, pc + 32'd4);
        end
        total++;
        if (bus.d_instr !== instr) begin
            bad++;
            $display("FAIL %s d_instr got=%h exp=%h", name, bus.d_instr, instr);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (bus.d_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset d_valid got=%b exp=0", bus.d_valid);
        end
        total++;
        if (bus.d_instr !== 32'h0) begin
            bad++;
            $display("FAIL reset d_instr got=%h exp=0", bus.d_instr);
        end
        total++;
        if (bus.d_pc !== 32'h0 || bus.d_pc_plus4 !== 32'h4) begin
            bad++;
            $display("FAIL reset pc got=%h/%h exp=0/4", bus.d_pc, bus.d_pc_plus4);
        end
        total++;
        if (bus.imem_addr !== 9'h0) begin
            bad++;
            $display("FAIL reset imem_addr got=%h exp=0", bus.imem_addr);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc();
            expect_out("seq", 32'(4 * i), BASE + 32'(i));
        end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (3) cyc();
        bus.stall = 1'b1;
        expect_out("stall_a", 32'd8, BASE + 32'd2);
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (i == 2) bus.stall = 1'b0;
            expect_out("stall_hold", 32'd8, BASE + 32'd2);
        end
        cyc();
        expect_out("stall_rel1", 32'd12, BASE + 32'd3);
        cyc();
        expect_out("stall_rel2", 32'd16, BASE + 32'd4);
    endtask

    task automatic test_enable();
        do_reset();
        repeat (4) cyc();
        bus.en = 1'b0;
        expect_out("en_a", 32'd12, BASE + 32'd3);
        cyc();
        expect_out("en_b", 32'd12, BASE + 32'd3);
        cyc();
        bus.en = 1'b1;
        expect_out("en_c", 32'd12, BASE + 32'd3);
        cyc();
        expect_out("en_r1", 32'd16, BASE + 32'd4);
        cyc();
        expect_out("en_r2", 32'd20, BASE + 32'd5);
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (5) cyc();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        expect_out("redir_br", 32'd16, BASE + 32'd4);
        cyc();
        bus.redirect_valid = 1'b0;
        expect_out("redir_slot", 32'd20, BASE + 32'd5);
        cyc();
        expect_out("redir_tgt", 32'h40, BASE + 32'd16);
        cyc();
        expect_out("redir_tgt4", 32'h44, BASE + 32'd17);
    endtask

    task automatic test_redirect_stall();
        do_reset();
        repeat (7) cyc();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        bus.stall          = 1'b1;
        expect_out("rs_a", 32'd24, BASE + 32'd6);
        cyc();
        bus.redirect_valid = 1'b0;
        bus.stall          = 1'b0;
        expect_out("rs_rel", 32'd24, BASE + 32'd6);
        cyc();
        expect_out("rs_next", 32'd28, BASE + 32'd7);
        cyc();
        expect_out("rs_next2", 32'd32, BASE + 32'd8);
    endtask

    task automatic test_back_to_back();
        do_reset();
        cyc();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        expect_out("b2b_0", 32'd0, BASE);
        cyc();
        bus.redirect_pc    = 32'h200;
        expect_out("b2b_slot", 32'd4, BASE + 32'd1);
        cyc();
        bus.redirect_valid = 1'b0;
        expect_out("b2b_t1", 32'h100, BASE + 32'd64);
        cyc();
        expect_out("b2b_t2", 32'h200, BASE + 32'd128);
    endtask

    task automatic test_wrap();
        do_reset();
        cyc();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        cyc();
        bus.redirect_valid = 1'b0;
        total++;
        if (bus.imem_addr !== 9'h1FF) begin
            bad++;
            $display("FAIL wrap imem_addr got=%h exp=1ff", bus.imem_addr);
        end
        cyc();
        expect_out("wrap_top", 32'hFFFF_FFFC, BASE + 32'd511);
        total++;
        if (bus.d_pc_plus4 !== 32'h0) begin
            bad++;
            $display("FAIL wrap d_pc_plus4 got=%h exp=0", bus.d_pc_plus4);
        end
        cyc();
        expect_out("wrap_zero", 32'h0, BASE);
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (3) cyc();
        expect_out("ar_pre", 32'd8, BASE + 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.d_valid !== 1'b0 || bus.d_instr !== 32'h0) begin
            bad++;
            $display("FAIL ar_now valid/instr got=%b/%h exp=0/0", bus.d_valid, bus.d_instr);
        end
        total++;
        if (bus.d_pc !== 32'h0 || bus.imem_addr !== 9'h0) begin
            bad++;
            $display("FAIL ar_now pc/addr got=%h/%h exp=0/0", bus.d_pc, bus.imem_addr);
        end
        cyc();
        #2;
        rst_n = 1'b1;
        total++;
        if (bus.d_valid !== 1'b0) begin
            bad++;
            $display("FAIL ar_rel d_valid got=%b exp=0", bus.d_valid);
        end
        cyc();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h43;
        expect_out("ar_restart", 32'd0, BASE);
        cyc();
        bus.redirect_valid = 1'b0;
        expect_out("ar_slot", 32'd4, BASE + 32'd1);
        cyc();
        expect_out("ar_align", 32'h40, BASE + 32'd16);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = BASE + 32'(i);
        bus.imem_rdata     = 32'h0;
        bus.en             = 1'b0;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_enable();
        test_redirect();
        test_redirect_stall();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // safety net so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
